// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state encoding,
// opcode values, ALU-operation codes, mux select codes and the bundle of
// datapath control strobes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXE  = 4'd6,
    RTWB   = 4'd7,
    BEQEX  = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JEX    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control strobes produced by the FSM in one cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_src;
  } ctrl_t;

  // States whose exit into FETCH completes an instruction.
  function automatic logic is_last_state(input state_e st);
    return (st == MEMWB) || (st == MEMWR) || (st == RTWB) ||
           (st == BEQEX) || (st == ADDIWB) || (st == JEX);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: a Moore FSM sequencing fetch, decode and
// the per-class execute steps, plus a retired-instruction counter.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit SUPPORT_J = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_e           r_state;
  state_e           w_next;
  ctrl_t            w_ctrl;
  logic             w_illegal;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_unused_zero;

  // The branch decision (pc_write_cond & zero) is formed in the datapath.
  assign w_unused_zero = zero;

  // State register; reset abandons any instruction in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  // Next-state and control decode from the current state.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    w_ctrl    = '0;
    w_illegal = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.aluop     = ALUOP_ADD;
        w_ctrl.pc_src    = PCSRC_ALU;
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_next          = DECODE;
        end
      end
      DECODE: begin
        w_ctrl.alu_src_b = SRCB_SHIFT;
        w_ctrl.aluop     = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = RTEXE;
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J: begin
            if (SUPPORT_J) begin
              w_next = JEX;
            end else begin
              w_next    = FETCH;
              w_illegal = 1'b1;
            end
          end
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.aluop     = ALUOP_ADD;
        w_next           = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_next            = FETCH;
      end
      MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
        if (mem_ready) w_next = FETCH;
      end
      RTEXE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REG;
        w_ctrl.aluop     = ALUOP_FUNCT;
        w_next           = RTWB;
      end
      RTWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_next           = FETCH;
      end
      BEQEX: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_REG;
        w_ctrl.aluop         = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_src        = PCSRC_ALUOUT;
        w_next               = FETCH;
      end
      ADDIEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.aluop     = ALUOP_ADD;
        w_next           = ADDIWB;
      end
      ADDIWB: begin
        w_ctrl.reg_write = 1'b1;
        w_next           = FETCH;
      end
      JEX: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = PCSRC_JUMP;
        w_next          = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

  // An instruction retires when its final state hands back to FETCH.
  always_comb begin
    w_retire = (w_next == FETCH) && is_last_state(r_state);
  end

  // Retired-instruction counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
  end

  // The state register is already FETCH during reset, but the mem_ready-gated
  // writes are combinational, so all architectural write strobes are masked.
  assign pc_write      = w_ctrl.pc_write & rst_n;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign iord          = w_ctrl.iord;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write & rst_n;
  assign ir_write      = w_ctrl.ir_write & rst_n;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write & rst_n;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign aluop         = w_ctrl.aluop;
  assign pc_src        = w_ctrl.pc_src;
  assign illegal_op    = w_illegal & rst_n;
  assign instr_count   = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. The stimulus process pushes the
// expected control word for each cycle into a scoreboard queue; a monitor on
// the falling edge pops and compares against both controller instances.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_src;
    logic       illegal_op;
  } tb_ctrl_t;

  typedef struct packed {
    tb_ctrl_t    c;
    logic [31:0] cnt;
    logic        nj_chk;
    logic        nj_ill;
    logic [1:0]  nj_cnt;
    logic [15:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_nj;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, aluop, pc_src;
  logic [31:0] instr_count;

  logic        nj_pc_write, nj_pc_write_cond, nj_iord, nj_mem_read, nj_mem_write;
  logic        nj_ir_write, nj_mem_to_reg, nj_reg_dst, nj_reg_write, nj_alu_src_a;
  logic        nj_illegal_op;
  logic [1:0]  nj_alu_src_b, nj_aluop, nj_pc_src;
  logic [1:0]  nj_instr_count;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_cmp  = 0;
  int          n_miss = 0;
  int          vec_id = 0;
  logic        g_nj_chk = 1'b0;
  logic        g_nj_ill = 1'b0;
  logic [1:0]  g_nj_cnt = 2'd0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.SUPPORT_J(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .pc_src(pc_src), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  mips_multicycle_ctrl #(.SUPPORT_J(1'b0), .CNT_W(2)) dut_nj (
    .clk(clk), .rst_n(rst_nj), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(nj_pc_write), .pc_write_cond(nj_pc_write_cond), .iord(nj_iord),
    .mem_read(nj_mem_read), .mem_write(nj_mem_write), .ir_write(nj_ir_write),
    .mem_to_reg(nj_mem_to_reg), .reg_dst(nj_reg_dst), .reg_write(nj_reg_write),
    .alu_src_a(nj_alu_src_a), .alu_src_b(nj_alu_src_b), .aluop(nj_aluop),
    .pc_src(nj_pc_src), .illegal_op(nj_illegal_op), .instr_count(nj_instr_count)
  );

  // Hand-written control table: what each state must drive.
  function automatic tb_ctrl_t exp_ctrl(input state_e st, input logic gate, input logic ill);
    tb_ctrl_t c;
    c = '0;
    case (st)
      FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01;
                    c.ir_write = gate; c.pc_write = gate; end
      DECODE: begin c.alu_src_b = 2'b11; c.illegal_op = ill; end
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      RTEXE:  begin c.alu_src_a = 1'b1; c.aluop = 2'b10; end
      RTWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      BEQEX:  begin c.alu_src_a = 1'b1; c.aluop = 2'b01;
                    c.pc_write_cond = 1'b1; c.pc_src = 2'b01; end
      ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDIWB: begin c.reg_write = 1'b1; end
      JEX:    begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic check(input string nm, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %h, expected %h", id, nm, act, exp);
    end
  endtask

  // One clock cycle: set mem_ready, queue the expectation, advance past the edge.
  task automatic cyc(input state_e st, input logic rdy, input logic ill,
                     input logic [31:0] cnt);
    exp_t e;
    mem_ready = rdy;
    e.c      = exp_ctrl(st, rdy & rst_n, ill);
    e.cnt    = cnt;
    e.nj_chk = g_nj_chk;
    e.nj_ill = g_nj_ill;
    e.nj_cnt = g_nj_cnt;
    e.id     = 16'(vec_id);
    vec_id++;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT outputs every falling edge with a pending vector.
  always @(negedge clk) begin : monitor
    exp_t     e;
    tb_ctrl_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      a.pc_write      = pc_write;
      a.pc_write_cond = pc_write_cond;
      a.iord          = iord;
      a.mem_read      = mem_read;
      a.mem_write     = mem_write;
      a.ir_write      = ir_write;
      a.mem_to_reg    = mem_to_reg;
      a.reg_dst       = reg_dst;
      a.reg_write     = reg_write;
      a.alu_src_a     = alu_src_a;
      a.alu_src_b     = alu_src_b;
      a.aluop         = aluop;
      a.pc_src        = pc_src;
      a.illegal_op    = illegal_op;
      check("ctrl", int'(e.id), 64'(a), 64'(e.c));
      check("instr_count", int'(e.id), 64'(instr_count), 64'(e.cnt));
      if (e.nj_chk) begin
        check("nj_illegal_op", int'(e.id), 64'(nj_illegal_op), 64'(e.nj_ill));
        check("nj_instr_count", int'(e.id), 64'(nj_instr_count), 64'(e.nj_cnt));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    rst_nj    = 1'b0;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Held in reset: FETCH decode, write strobes masked even with mem_ready.
    cyc(FETCH, 1'b0, 1'b0, 0);
    cyc(FETCH, 1'b1, 1'b0, 0);
    rst_n = 1'b1;

    // R-type: FETCH, DECODE, RTEXE, RTWB -> count 1.
    opcode = 6'b000000;
    cyc(FETCH, 1'b1, 1'b0, 0);
    cyc(DECODE, 1'b0, 1'b0, 0);
    cyc(RTEXE, 1'b0, 1'b0, 0);
    cyc(RTWB, 1'b0, 1'b0, 0);

    // lw with two wait states in MEMRD.
    opcode = 6'b100011;
    cyc(FETCH, 1'b1, 1'b0, 1);
    cyc(DECODE, 1'b0, 1'b0, 1);
    cyc(MEMADR, 1'b0, 1'b0, 1);
    cyc(MEMRD, 1'b0, 1'b0, 1);
    cyc(MEMRD, 1'b0, 1'b0, 1);
    cyc(MEMRD, 1'b1, 1'b0, 1);
    cyc(MEMWB, 1'b0, 1'b0, 1);

    // sw with one fetch wait and one write wait.
    opcode = 6'b101011;
    cyc(FETCH, 1'b0, 1'b0, 2);
    cyc(FETCH, 1'b1, 1'b0, 2);
    cyc(DECODE, 1'b0, 1'b0, 2);
    cyc(MEMADR, 1'b0, 1'b0, 2);
    cyc(MEMWR, 1'b0, 1'b0, 2);
    cyc(MEMWR, 1'b1, 1'b0, 2);

    // beq: 3 cycles.
    opcode = 6'b000100;
    zero   = 1'b1;
    cyc(FETCH, 1'b1, 1'b0, 3);
    cyc(DECODE, 1'b0, 1'b0, 3);
    cyc(BEQEX, 1'b0, 1'b0, 3);
    zero   = 1'b0;

    // addi: 4 cycles.
    opcode = 6'b001000;
    cyc(FETCH, 1'b1, 1'b0, 4);
    cyc(DECODE, 1'b0, 1'b0, 4);
    cyc(ADDIEX, 1'b0, 1'b0, 4);
    cyc(ADDIWB, 1'b0, 1'b0, 4);

    // Undecoded opcode: one-cycle pulse, back to FETCH, not counted.
    opcode = 6'b111111;
    cyc(FETCH, 1'b1, 1'b0, 5);
    cyc(DECODE, 1'b0, 1'b1, 5);

    // j with SUPPORT_J=1: 3 cycles.
    opcode = 6'b000010;
    cyc(FETCH, 1'b1, 1'b0, 5);
    cyc(DECODE, 1'b0, 1'b0, 5);
    cyc(JEX, 1'b0, 1'b0, 5);

    // sw abandoned by reset while in MEMWR.
    opcode = 6'b101011;
    cyc(FETCH, 1'b1, 1'b0, 6);
    cyc(DECODE, 1'b0, 1'b0, 6);
    cyc(MEMADR, 1'b0, 1'b0, 6);
    cyc(MEMWR, 1'b0, 1'b0, 6);
    rst_n = 1'b0;
    cyc(FETCH, 1'b1, 1'b0, 0);
    rst_n  = 1'b1;
    rst_nj = 1'b1;

    // Four beq on both instances; the 2-bit counter wraps back to 0.
    g_nj_chk = 1'b1;
    opcode   = 6'b000100;
    for (int k = 0; k < 4; k++) begin
      g_nj_cnt = 2'(k);
      cyc(FETCH, 1'b1, 1'b0, 32'(k));
      cyc(DECODE, 1'b0, 1'b0, 32'(k));
      cyc(BEQEX, 1'b0, 1'b0, 32'(k));
    end

    // j: illegal on the SUPPORT_J=0 instance, JEX on the other.
    opcode   = 6'b000010;
    g_nj_cnt = 2'd0;
    cyc(FETCH, 1'b1, 1'b0, 4);
    g_nj_ill = 1'b1;
    cyc(DECODE, 1'b0, 1'b0, 4);
    g_nj_ill = 1'b0;
    g_nj_chk = 1'b0;
    cyc(JEX, 1'b0, 1'b0, 4);
    cyc(FETCH, 1'b0, 1'b0, 5);

    // Drain the scoreboard within a bounded number of cycles.
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
